// File: rtl/cpu_driver.sv
// Initiator for the cpu load/start/waiting handshake: queues 16-bit instructions,
// issues them one at a time and reports the cpu result and flags per instruction.
module cpu_driver #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  output logic        in_ready,
  output logic        cpu_load,
  output logic        cpu_start,
  output logic [15:0] cpu_instr,
  input  logic        cpu_waiting,
  input  logic [15:0] cpu_out,
  input  logic        cpu_N,
  input  logic        cpu_V,
  input  logic        cpu_Z,
  output logic        res_valid,
  output logic [15:0] res_out,
  output logic [2:0]  res_flags,
  output logic        busy,
  output logic        timeout_err,
  output logic [7:0]  issued_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  // Timer starts at 0 the cycle after the start pulse; this makes timeout_err rise
  // exactly TIMEOUT cycles after cpu_start.
  localparam logic [TW-1:0] ERR_AT = TW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_REPORT, S_ERROR
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [15:0]     cpu_instr_q, cpu_instr_d;
  logic            cpu_load_q, cpu_load_d;
  logic            cpu_start_q, cpu_start_d;
  logic            res_valid_q, res_valid_d;
  logic [15:0]     res_out_q, res_out_d;
  logic [2:0]      res_flags_q, res_flags_d;
  logic            busy_q, busy_d;
  logic            in_ready_q, in_ready_d;
  logic            timeout_err_q, timeout_err_d;
  logic [7:0]      issued_cnt_q, issued_cnt_d;
  logic            push, pop;

  assign push = in_valid && in_ready_q;
  assign pop  = (state_q == S_START);

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d       = count_q + CW'(push) - CW'(pop);
    timer_d       = timer_q;
    cpu_instr_d   = cpu_instr_q;
    cpu_load_d    = 1'b0;
    cpu_start_d   = 1'b0;
    res_valid_d   = 1'b0;
    res_out_d     = res_out_q;
    res_flags_d   = res_flags_q;
    timeout_err_d = timeout_err_q;
    issued_cnt_d  = issued_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0 && cpu_waiting) begin
          state_d     = S_LOAD;
          cpu_instr_d = mem[rd_ptr_q];
          cpu_load_d  = 1'b1;
        end
      end
      S_LOAD: begin
        state_d     = S_START;
        cpu_start_d = 1'b1;
      end
      S_START: begin
        state_d = S_WAIT_BUSY;
        timer_d = '0;
      end
      S_WAIT_BUSY: begin
        if (!cpu_waiting) begin
          state_d = S_WAIT_DONE;
          timer_d = timer_q + TW'(1);
        end else if (timer_q == ERR_AT) begin
          state_d       = S_ERROR;
          timeout_err_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (cpu_waiting) begin
          state_d      = S_REPORT;
          res_valid_d  = 1'b1;
          res_out_d    = cpu_out;
          res_flags_d  = {cpu_Z, cpu_V, cpu_N};
          issued_cnt_d = issued_cnt_q + 8'd1;
        end else if (timer_q == ERR_AT) begin
          state_d       = S_ERROR;
          timeout_err_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_REPORT: state_d = S_IDLE;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_IDLE;
    endcase

    // Full blocks push even when a pop happens the same cycle.
    busy_d     = (state_d != S_IDLE) || (count_d != '0);
    in_ready_d = (count_d != FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      timer_q       <= '0;
      cpu_instr_q   <= '0;
      cpu_load_q    <= 1'b0;
      cpu_start_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_out_q     <= '0;
      res_flags_q   <= '0;
      busy_q        <= 1'b0;
      in_ready_q    <= 1'b1;
      timeout_err_q <= 1'b0;
      issued_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      timer_q       <= timer_d;
      cpu_instr_q   <= cpu_instr_d;
      cpu_load_q    <= cpu_load_d;
      cpu_start_q   <= cpu_start_d;
      res_valid_q   <= res_valid_d;
      res_out_q     <= res_out_d;
      res_flags_q   <= res_flags_d;
      busy_q        <= busy_d;
      in_ready_q    <= in_ready_d;
      timeout_err_q <= timeout_err_d;
      issued_cnt_q  <= issued_cnt_d;
    end
  end

  // Storage needs no reset; occupancy governs what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_instr;
  end

  assign in_ready    = in_ready_q;
  assign cpu_load    = cpu_load_q;
  assign cpu_start   = cpu_start_q;
  assign cpu_instr   = cpu_instr_q;
  assign res_valid   = res_valid_q;
  assign res_out     = res_out_q;
  assign res_flags   = res_flags_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign issued_cnt  = issued_cnt_q;

endmodule

// File: tb/tb_cpu_driver.sv
// Directed bench for cpu_driver with a toy cpu stub (LDI, ADD R0+=R1, CMP R1,R0).
module tb_cpu_driver;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready, cpu_load, cpu_start, cpu_waiting;
  logic [15:0] cpu_instr, cpu_out;
  logic        cpu_N, cpu_V, cpu_Z;
  logic        res_valid, busy, timeout_err;
  logic [15:0] res_out;
  logic [2:0]  res_flags;
  logic [7:0]  issued_cnt;

  int n_checks = 0;
  int n_errors = 0;

  cpu_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .cpu_load(cpu_load), .cpu_start(cpu_start), .cpu_instr(cpu_instr),
    .cpu_waiting(cpu_waiting), .cpu_out(cpu_out), .cpu_N(cpu_N), .cpu_V(cpu_V), .cpu_Z(cpu_Z),
    .res_valid(res_valid), .res_out(res_out), .res_flags(res_flags), .busy(busy),
    .timeout_err(timeout_err), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Toy cpu: goes busy on start, finishes 4 cycles later, ignores rst.
  logic        wait_r = 1'b1;
  logic [3:0]  cnt = 4'd0;
  logic [15:0] ir = 16'h0, r0 = 16'h0, r1 = 16'h0, out_r = 16'h0;
  logic        n_f = 1'b0, z_f = 1'b0;
  logic        force_low = 1'b0, hang = 1'b0;
  logic [15:0] sum, diff;

  assign sum         = r0 + r1;
  assign diff        = r1 - r0;
  assign cpu_waiting = force_low ? 1'b0 : (hang ? 1'b1 : wait_r);
  assign cpu_out     = out_r;
  assign cpu_N       = n_f;
  assign cpu_V       = 1'b0;
  assign cpu_Z       = z_f;

  always @(posedge clk) begin
    if (cpu_load) ir <= cpu_instr;
    if (cpu_start) begin
      wait_r <= 1'b0;
      cnt    <= 4'd4;
    end else if (!wait_r) begin
      if (cnt != 4'd0) cnt <= cnt - 4'd1;
      else begin
        wait_r <= 1'b1;
        if (ir[15:12] == 4'hD) begin
          if (ir[8]) r1 <= {8'h00, ir[7:0]};
          else       r0 <= {8'h00, ir[7:0]};
          out_r <= {8'h00, ir[7:0]};
          z_f   <= (ir[7:0] == 8'h00);
          n_f   <= 1'b0;
        end else if (ir[15:12] == 4'hA && ir[11:8] == 4'h9) begin
          z_f <= (diff == 16'h0);
          n_f <= diff[15];
        end else if (ir[15:12] == 4'hA) begin
          r0    <= sum;
          out_r <= sum;
          z_f   <= (sum == 16'h0);
          n_f   <= sum[15];
        end
      end
    end
  end

  // Handshake monitor and result log.
  int          n_res = 0, n_load = 0;
  logic        prev_load = 1'b0, prev_start = 1'b0;
  logic [15:0] instr_at_load = 16'h0;
  logic [15:0] res_log [0:31];
  logic [15:0] last_out = 16'h0;
  logic [2:0]  last_flags = 3'b0;
  logic [7:0]  last_issued = 8'h0;

  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_load) begin
        check("load_start_excl", 32'(cpu_start), 32'd0);
        check("load_1cyc", 32'(prev_load), 32'd0);
        instr_at_load = cpu_instr;
        n_load++;
      end
      if (cpu_start) begin
        check("start_after_load", 32'(prev_load), 32'd1);
        check("start_1cyc", 32'(prev_start), 32'd0);
        check("instr_stable_start", 32'(cpu_instr), 32'(instr_at_load));
      end
      if (res_valid) begin
        check("instr_stable_res", 32'(cpu_instr), 32'(instr_at_load));
        if (n_res < 32) res_log[n_res] = res_out;
        last_out    = res_out;
        last_flags  = res_flags;
        last_issued = issued_cnt;
        n_res++;
      end
    end
    prev_load  = cpu_load;
    prev_start = cpu_start;
  end

  task automatic push(input logic [15:0] w);
    int b = 0;
    in_valid = 1'b1;
    in_instr = w;
    while (!in_ready && b < 2000) begin
      @(negedge clk);
      b++;
    end
    if (b >= 2000) begin
      n_checks++;
      n_errors++;
      $display("FAIL push_timeout: in_ready stuck low for word %0h", w);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input int target);
    int b = 0;
    while (n_res < target && b < 2000) begin
      @(negedge clk);
      b++;
    end
    @(negedge clk);
    check("res_count", 32'(n_res), 32'(target));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_load"}, 32'(cpu_load), 32'd0);
    check({tag, "_start"}, 32'(cpu_start), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = 16'h0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_err", 32'(timeout_err), 32'd0);
    check("reset_issued", 32'(issued_cnt), 32'd0);
    check("reset_res_out", 32'(res_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: async reset while in WAIT_DONE with three words queued
    push(16'hD011); push(16'hD012); push(16'hD013); push(16'hD014);
    for (int b = 0; b < 50 && cpu_waiting; b++) @(negedge clk);
    @(negedge clk);
    check("t1_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("t1_async_in_ready", 32'(in_ready), 32'd1);
    check("t1_async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("t1");
    repeat (12) @(negedge clk);
    check("t1_no_res", 32'(n_res), 32'd0);
    check("t1_no_issue", 32'(issued_cnt), 32'd0);
    check("t1_still_idle", 32'(busy), 32'd0);

    // 2: R0=7, R1=2, ADD -> 9
    push(16'hD007); push(16'hD102); push(16'hA041);
    wait_res(3);
    check("t2_res0", 32'(res_log[0]), 32'd7);
    check("t2_res1", 32'(res_log[1]), 32'd2);
    check("t2_res2", 32'(last_out), 32'd9);
    check("t2_flags", 32'(last_flags), 32'd0);
    check("t2_issued", 32'(last_issued), 32'd3);

    // 3: CMP R1,R0 -> N only, output unchanged
    push(16'hA900);
    wait_res(4);
    check("t3_flags", 32'(last_flags), 32'b001);
    check("t3_res_out", 32'(last_out), 32'd9);
    check("t3_issued", 32'(last_issued), 32'd4);
    repeat (5) @(negedge clk);
    check("t3_hold_out", 32'(res_out), 32'd9);
    check("t3_hold_flags", 32'(res_flags), 32'b001);

    // 4: cpu held busy, overfill FIFO by one
    force_low = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) push(16'hD010 + 16'(i));
    check("t4_full", 32'(in_ready), 32'd0);
    fork
      push(16'hD0EE);
    join_none
    repeat (5) @(negedge clk);
    check("t4_held", 32'(in_ready), 32'd0);
    check("t4_no_issue", 32'(n_res), 32'd4);
    force_low = 1'b0;
    wait_res(4 + DEPTH + 1);
    check("t4_first", 32'(res_log[4]), 32'h0010);
    check("t4_last16", 32'(res_log[4 + DEPTH - 1]), 32'h001F);
    check("t4_17th", 32'(last_out), 32'h00EE);
    check("t4_issued", 32'(last_issued), 32'd21);
    repeat (5) @(negedge clk);
    check("t4_idle", 32'(busy), 32'd0);

    // 5: cpu never goes busy -> sticky timeout
    hang = 1'b1;
    push(16'hD055);
    for (int b = 0; b < 50 && !cpu_start; b++) @(negedge clk);
    check("t5_start_seen", 32'(cpu_start), 32'd1);
    repeat (TIMEOUT - 1) @(negedge clk);
    check("t5_err_early", 32'(timeout_err), 32'd0);
    @(negedge clk);
    check("t5_err_set", 32'(timeout_err), 32'd1);
    begin
      int loads_at_err;
      loads_at_err = n_load;
      push(16'hD066);
      repeat (20) @(negedge clk);
      check("t5_no_more_issue", 32'(n_load), 32'(loads_at_err));
    end
    check("t5_err_sticky", 32'(timeout_err), 32'd1);
    check("t5_accepts", 32'(in_ready), 32'd1);
    check("t5_busy", 32'(busy), 32'd1);
    check("t5_issued", 32'(issued_cnt), 32'd21);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hang = 1'b0;
    @(negedge clk);
    check("t5_err_cleared", 32'(timeout_err), 32'd0);
    check("t5_issued_cleared", 32'(issued_cnt), 32'd0);
    check_idle_outputs("t5_post");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
